// File: rtl/bin_window_pkg.sv
// rtl/bin_window_pkg.sv - shared sizing helpers for the binarised window generator
package bin_window_pkg;

   // Counter width for a range of n values; never narrower than one bit
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Bits in one K x K patch carrying CH channels per pixel
   function automatic int patch_w(input int k, input int ch);
      return k * k * ch;
   endfunction

   // Patch origins reachable along one axis of length n
   function automatic int origins(input int n, input int k, input int s);
      return (n - k) / s + 1;
   endfunction

   // Patches produced per frame
   function automatic int num_patches(input int w, input int h, input int k, input int s);
      return origins(h, k, s) * origins(w, k, s);
   endfunction

   // Origin coordinate of the last reachable window along one axis
   function automatic int last_origin(input int n, input int k, input int s);
      return ((n - k) / s) * s;
   endfunction

endpackage

// File: rtl/bin_line_buffer.sv
// rtl/bin_line_buffer.sv - K-1 cascaded row buffers indexed by column
module bin_line_buffer
#(
   parameter int DEPTH = 28,
   parameter int WIDTH = 1,
   parameter int TAPS  = 2,
   parameter int AW    = 5
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  we_i,
   input  logic [AW-1:0]         addr_i,
   input  logic [WIDTH-1:0]      din_i,
   output logic [TAPS*WIDTH-1:0] taps_o
);

   logic [WIDTH-1:0] mem_q [TAPS][DEPTH];

   // Each write pushes the column one row deeper through the buffers
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int t = 0; t < TAPS; t++) begin
            for (int a = 0; a < DEPTH; a++) begin
               mem_q[t][a] <= '0;
            end
         end
      end else if (we_i) begin
         mem_q[0][addr_i] <= din_i;
         for (int t = 1; t < TAPS; t++) begin
            mem_q[t][addr_i] <= mem_q[t-1][addr_i];
         end
      end
   end

   // Tap t holds the pixel t+1 rows above the current column
   always_comb begin
      taps_o = '0;
      for (int t = 0; t < TAPS; t++) begin
         taps_o[t*WIDTH +: WIDTH] = mem_q[t][addr_i];
      end
   end

endmodule

// File: rtl/bin_window_gen.sv
// rtl/bin_window_gen.sv - streaming KxK binarised patch generator, BWG_COORD_EN adds patch origin outputs
module bin_window_gen
   import bin_window_pkg::*;
#(
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter int CH     = 1,
   parameter int K      = 3,
   parameter int STRIDE = 1
)
(
   input  logic                        clk,
   input  logic                        reset,
   input  logic [CH-1:0]               in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic [patch_w(K, CH)-1:0]   out_patch,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        out_last
`ifdef BWG_COORD_EN
   ,
   output logic [cnt_w(IMG_H)-1:0]     out_prow,
   output logic [cnt_w(IMG_W)-1:0]     out_pcol
`endif
);

   localparam int RW = cnt_w(IMG_H);
   localparam int CW = cnt_w(IMG_W);
   localparam int SW = cnt_w(STRIDE);
   localparam int PW = patch_w(K, CH);

   localparam logic [RW-1:0] ROW_MAX  = RW'(IMG_H - 1);
   localparam logic [RW-1:0] ROW_K1   = RW'(K - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(K - 1 + last_origin(IMG_H, K, STRIDE));
   localparam logic [CW-1:0] COL_MAX  = CW'(IMG_W - 1);
   localparam logic [CW-1:0] COL_K1   = CW'(K - 1);
   localparam logic [CW-1:0] COL_LAST = CW'(K - 1 + last_origin(IMG_W, K, STRIDE));
   localparam logic [SW-1:0] PH_MAX   = SW'(STRIDE - 1);

   logic [RW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;
   logic [SW-1:0] rph_q, rph_d;
   logic [SW-1:0] cph_q, cph_d;

   logic [CH-1:0] win_q [K][K];
   logic [CH-1:0] win_d [K][K];
   logic [CH-1:0] feed  [K];
   logic [(K-1)*CH-1:0] taps;

   logic [PW-1:0] patch_d;
   logic [PW-1:0] out_patch_q;
   logic          out_valid_q;
   logic          out_last_q;
   logic          accept;
   logic          emit;
   logic          is_last;

   assign in_ready  = !out_valid_q || out_ready;
   assign accept    = in_valid && in_ready;
   assign out_patch = out_patch_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;

   // Stride phases restart as the window first becomes full on each axis
   always_comb begin
      row_d = row_q;
      col_d = col_q;
      rph_d = rph_q;
      cph_d = cph_q;
      if (accept) begin
         cph_d = (col_q < COL_K1 || cph_q == PH_MAX) ? '0 : cph_q + SW'(1);
         if (col_q == COL_MAX) begin
            col_d = '0;
            rph_d = (row_q < ROW_K1 || rph_q == PH_MAX) ? '0 : rph_q + SW'(1);
            row_d = (row_q == ROW_MAX) ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   assign emit    = accept && (row_q >= ROW_K1) && (col_q >= COL_K1) &&
                    (rph_q == '0) && (cph_q == '0);
   assign is_last = (row_q == ROW_LAST) && (col_q == COL_LAST);

   bin_line_buffer #(
      .DEPTH (IMG_W),
      .WIDTH (CH),
      .TAPS  (K - 1),
      .AW    (CW)
   ) u_lb (
      .clk    (clk),
      .reset  (reset),
      .we_i   (accept),
      .addr_i (col_q),
      .din_i  (in_data),
      .taps_o (taps)
   );

   // Next window: every row slides left and takes the newest column on the right
   always_comb begin
      feed[K-1] = in_data;
      for (int j = 0; j < K - 1; j++) begin
         feed[j] = taps[(K-2-j)*CH +: CH];
      end
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K - 1; c++) begin
            win_d[r][c] = win_q[r][c+1];
         end
         win_d[r][K-1] = feed[r];
      end
      patch_d = '0;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K; c++) begin
            patch_d[((r*K)+c)*CH +: CH] = win_d[r][c];
         end
      end
   end

   // Raster counters, stride phases and window advance only on an accepted pixel
   always_ff @(posedge clk) begin
      if (reset) begin
         row_q <= '0;
         col_q <= '0;
         rph_q <= '0;
         cph_q <= '0;
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
               win_q[r][c] <= '0;
            end
         end
      end else begin
         row_q <= row_d;
         col_q <= col_d;
         rph_q <= rph_d;
         cph_q <= cph_d;
         if (accept) begin
            for (int r = 0; r < K; r++) begin
               for (int c = 0; c < K; c++) begin
                  win_q[r][c] <= win_d[r][c];
               end
            end
         end
      end
   end

   // Single output register: load on emit, hold until taken, drop when drained
   always_ff @(posedge clk) begin
      if (reset) begin
         out_patch_q <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else if (emit) begin
         out_patch_q <= patch_d;
         out_valid_q <= 1'b1;
         out_last_q  <= is_last;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

`ifdef BWG_COORD_EN
   logic [RW-1:0] out_prow_q;
   logic [CW-1:0] out_pcol_q;

   assign out_prow = out_prow_q;
   assign out_pcol = out_pcol_q;

   // Patch origin is the window's top-left pixel, captured with the patch
   always_ff @(posedge clk) begin
      if (reset) begin
         out_prow_q <= '0;
         out_pcol_q <= '0;
      end else if (emit) begin
         out_prow_q <= row_q - ROW_K1;
         out_pcol_q <= col_q - COL_K1;
      end
   end
`endif

endmodule

// File: tb/tb_bin_window_gen.sv
// tb/tb_bin_window_gen.sv - self-checking bench for bin_window_gen on 5x5 frames
module tb_bin_window_gen;

   localparam int W  = 5;
   localparam int H  = 5;
   localparam int KK = 3;

   typedef struct {
      int          d;
      logic [35:0] p;
      bit          last;
      int          pr;
      int          pc;
   } rec_t;

   typedef struct {
      int          test;
      int          idx;
      logic [35:0] p;
      bit          last;
   } vec_t;

   logic        clk;
   logic        reset;
   logic        in_valid  [3];
   logic [3:0]  in_data   [3];
   logic        out_ready [3];
   logic        in_ready  [3];
   logic        out_valid [3];
   logic        out_last  [3];
   logic [35:0] patch     [3];
   logic [8:0]  p0, p1;
   logic [35:0] p2;
`ifdef BWG_COORD_EN
   logic [2:0]  prow [3];
   logic [2:0]  pcol [3];
`endif

   assign patch[0] = 36'(p0);
   assign patch[1] = 36'(p1);
   assign patch[2] = p2;

   rec_t exp_q[$];
   rec_t got_q[$];
   rec_t saved[$];
   logic [3:0] frame [25];
   vec_t tbl [7];
   int   checks   = 0;
   int   failures = 0;
   int   rdy_mode [3];
   bit   bp_arm;
   int   hold_cnt;
   bit   stalled [3];
   logic [35:0] held [3];

   bin_window_gen #(.IMG_W(W), .IMG_H(H), .CH(1), .K(KK), .STRIDE(1)) dut0 (
      .clk(clk), .reset(reset), .in_data(in_data[0][0:0]), .in_valid(in_valid[0]),
      .in_ready(in_ready[0]), .out_patch(p0), .out_valid(out_valid[0]),
      .out_ready(out_ready[0]), .out_last(out_last[0])
`ifdef BWG_COORD_EN
      , .out_prow(prow[0]), .out_pcol(pcol[0])
`endif
   );

   bin_window_gen #(.IMG_W(W), .IMG_H(H), .CH(1), .K(KK), .STRIDE(2)) dut1 (
      .clk(clk), .reset(reset), .in_data(in_data[1][0:0]), .in_valid(in_valid[1]),
      .in_ready(in_ready[1]), .out_patch(p1), .out_valid(out_valid[1]),
      .out_ready(out_ready[1]), .out_last(out_last[1])
`ifdef BWG_COORD_EN
      , .out_prow(prow[1]), .out_pcol(pcol[1])
`endif
   );

   bin_window_gen #(.IMG_W(W), .IMG_H(H), .CH(4), .K(KK), .STRIDE(1)) dut2 (
      .clk(clk), .reset(reset), .in_data(in_data[2]), .in_valid(in_valid[2]),
      .in_ready(in_ready[2]), .out_patch(p2), .out_valid(out_valid[2]),
      .out_ready(out_ready[2]), .out_last(out_last[2])
`ifdef BWG_COORD_EN
      , .out_prow(prow[2]), .out_pcol(pcol[2])
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // Consumer side: out_ready per instance, with an optional 10-cycle hold on the first patch
   initial begin
      for (int d = 0; d < 3; d++) out_ready[d] = 1'b1;
      hold_cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         for (int d = 0; d < 3; d++) begin
            if (rdy_mode[d] == 0) begin
               out_ready[d] = 1'b1;
            end else if (hold_cnt > 0) begin
               out_ready[d] = 1'b0;
               hold_cnt--;
            end else if (bp_arm && out_valid[d]) begin
               bp_arm        = 1'b0;
               hold_cnt      = 9;
               out_ready[d]  = 1'b0;
            end else begin
               out_ready[d] = ($urandom_range(0, 3) != 0);
            end
         end
      end
   end

   // Monitor: record handshaken patches, check stall behaviour
   initial begin
      rec_t r;
      forever begin
         @(negedge clk);
         if (!reset) begin
            for (int d = 0; d < 3; d++) begin
               if (out_valid[d] && out_ready[d]) begin
                  r.d = d; r.p = patch[d]; r.last = out_last[d]; r.pr = 0; r.pc = 0;
`ifdef BWG_COORD_EN
                  r.pr = int'(prow[d]); r.pc = int'(pcol[d]);
`endif
                  got_q.push_back(r);
                  stalled[d] = 1'b0;
               end else if (out_valid[d]) begin
                  chk("in_ready_stall", 64'(in_ready[d]), 64'd0);
                  if (stalled[d]) chk("patch_stable", 64'(patch[d]), 64'(held[d]));
                  stalled[d] = 1'b1;
                  held[d]    = patch[d];
               end else begin
                  stalled[d] = 1'b0;
               end
            end
         end
      end
   end

   task automatic send_pixel(input int d, input logic [3:0] v, input int gap);
      int n;
      bit acc;
      for (int g = 0; g < gap; g++) begin
         @(posedge clk);
         #1;
      end
      in_valid[d] = 1'b1;
      in_data[d]  = v;
      n = 0;
      acc = 1'b0;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = in_ready[d];
         @(posedge clk);
         #1;
         n++;
      end
      in_valid[d] = 1'b0;
      chk("accept_in_time", 64'(acc), 64'd1);
   endtask

   task automatic send_frame(input int d, input int npix, input int gapmax);
      for (int i = 0; i < npix; i++) begin
         send_pixel(d, frame[i], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
      end
   endtask

   task automatic rand_frame(input int d);
      for (int i = 0; i < 25; i++) begin
         frame[i] = (d == 2) ? 4'($urandom) : {3'b000, 1'($urandom)};
      end
   endtask

   // Reference: enumerate window origins by stride and gather bits straight from the frame
   task automatic model_frame(input int d);
      int   ch;
      int   s;
      rec_t r;
      ch = (d == 2) ? 4 : 1;
      s  = (d == 1) ? 2 : 1;
      for (int orow = 0; orow <= H - KK; orow += s) begin
         for (int ocol = 0; ocol <= W - KK; ocol += s) begin
            r.d = d; r.p = '0; r.pr = orow; r.pc = ocol;
            r.last = (orow + s > H - KK) && (ocol + s > W - KK);
            for (int rr = 0; rr < KK; rr++)
               for (int c = 0; c < KK; c++)
                  for (int k = 0; k < ch; k++)
                     r.p[((rr*KK)+c)*ch + k] = frame[(orow+rr)*W + ocol + c][k];
            exp_q.push_back(r);
         end
      end
   endtask

   task automatic drain_compare(input string name);
      int n;
      n = 0;
      while ((got_q.size() < exp_q.size() || out_valid[0] || out_valid[1] || out_valid[2])
             && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk($sformatf("%s_count", name), 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         chk($sformatf("%s_inst[%0d]", name, i), 64'(got_q[i].d), 64'(exp_q[i].d));
         chk($sformatf("%s_patch[%0d]", name, i), 64'(got_q[i].p), 64'(exp_q[i].p));
         chk($sformatf("%s_last[%0d]", name, i), 64'(got_q[i].last), 64'(exp_q[i].last));
`ifdef BWG_COORD_EN
         chk($sformatf("%s_prow[%0d]", name, i), 64'(got_q[i].pr), 64'(exp_q[i].pr));
         chk($sformatf("%s_pcol[%0d]", name, i), 64'(got_q[i].pc), 64'(exp_q[i].pc));
`endif
      end
      saved = got_q;
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic check_table(input int test);
      for (int i = 0; i < 7; i++) begin
         if (tbl[i].test == test) begin
            if (tbl[i].idx < saved.size()) begin
               chk($sformatf("tbl%0d_patch[%0d]", test, tbl[i].idx), 64'(saved[tbl[i].idx].p), 64'(tbl[i].p));
               chk($sformatf("tbl%0d_last[%0d]", test, tbl[i].idx), 64'(saved[tbl[i].idx].last), 64'(tbl[i].last));
            end else begin
               chk($sformatf("tbl%0d_present[%0d]", test, tbl[i].idx), 64'(saved.size()), 64'(tbl[i].idx + 1));
            end
         end
      end
   endtask

   task automatic check_outputs_zero(input string name);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("%s_valid%0d", name, d), 64'(out_valid[d]), 64'd0);
         chk($sformatf("%s_last%0d", name, d), 64'(out_last[d]), 64'd0);
         chk($sformatf("%s_patch%0d", name, d), 64'(patch[d]), 64'd0);
      end
   endtask

   initial begin
      tbl[0] = '{1, 0, 36'h100, 1'b0};
      tbl[1] = '{1, 4, 36'h010, 1'b0};
      tbl[2] = '{1, 8, 36'h001, 1'b1};
      tbl[3] = '{2, 0, 36'h100, 1'b0};
      tbl[4] = '{2, 1, 36'h040, 1'b0};
      tbl[5] = '{2, 2, 36'h004, 1'b0};
      tbl[6] = '{2, 3, 36'h001, 1'b1};

      for (int d = 0; d < 3; d++) begin
         in_valid[d] = 1'b0;
         in_data[d]  = '0;
         rdy_mode[d] = 0;
         stalled[d]  = 1'b0;
      end
      bp_arm = 1'b0;
      reset  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset_state");
      reset = 1'b0;
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) chk($sformatf("idle_in_ready%0d", d), 64'(in_ready[d]), 64'd1);

      // Impulse at raster (2,2), stride 1
      for (int i = 0; i < 25; i++) frame[i] = '0;
      frame[12] = 4'h1;
      model_frame(0);
      send_frame(0, 25, 0);
      drain_compare("impulse");
      check_table(1);

      // Same impulse, stride 2
      model_frame(1);
      send_frame(1, 25, 0);
      drain_compare("stride");
      check_table(2);

      // Four channels, random in_valid gaps, first patch held for 10 cycles, then random ready
      rdy_mode[2] = 1;
      bp_arm      = 1'b1;
      for (int f = 0; f < 2; f++) begin
         rand_frame(2);
         model_frame(2);
         send_frame(2, 25, 2);
      end
      drain_compare("backpressure");
      chk("hold_happened", 64'(bp_arm), 64'd0);
      rdy_mode[2] = 0;

      // Random stride-2 frames with random consumer stalls
      rdy_mode[1] = 1;
      for (int f = 0; f < 2; f++) begin
         rand_frame(1);
         model_frame(1);
         send_frame(1, 25, 1);
      end
      drain_compare("stride_rand");
      rdy_mode[1] = 0;

      // Two back-to-back frames with no gap
      for (int f = 0; f < 2; f++) begin
         rand_frame(0);
         model_frame(0);
         send_frame(0, 25, 0);
      end
      drain_compare("wrap");

      // Reset after 12 pixels, then a clean frame
      rand_frame(2);
      send_frame(2, 12, 0);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      chk("partial_no_patch", 64'(got_q.size()), 64'd0);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_outputs_zero("mid_reset");
      reset = 1'b0;
      got_q.delete();
      rand_frame(2);
      model_frame(2);
      send_frame(2, 25, 0);
      drain_compare("after_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
